// File: rtl/gpio_apb_arb_if.sv
// Purpose : bundles the two requester ports and the APB pins in front of gpio_lite.
// Ports   : reqN_* request/grant/done/rdata per requester (N=0,1); psel/penable/pwrite/
//           paddr/pwdata toward gpio_lite, prdata back. slave = arbiter side, master = users.
interface gpio_apb_arb_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req0_req;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_lock;
  logic              req0_gnt;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_req;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_lock;
  logic              req1_gnt;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;

  modport slave (
    input  req0_req, req0_we, req0_addr, req0_wdata, req0_lock,
    output req0_gnt, req0_done, req0_rdata,
    input  req1_req, req1_we, req1_addr, req1_wdata, req1_lock,
    output req1_gnt, req1_done, req1_rdata,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata
  );

  modport master (
    output req0_req, req0_we, req0_addr, req0_wdata, req0_lock,
    input  req0_gnt, req0_done, req0_rdata,
    output req1_req, req1_we, req1_addr, req1_wdata, req1_lock,
    input  req1_gnt, req1_done, req1_rdata,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata
  );
endinterface

// File: rtl/gpio_apb_arb.sv
// Purpose : round-robin (with RMW lock) arbiter serialising two requesters onto one APB port.
// Latency : gnt combinational in cycle A; SETUP at A+1, ACCESS at A+2, done/rdata at A+3.
// Backpressure: a request waits (req held) until gnt; peak one transfer per 2 cycles.
// Ports   : pclk, p_reset (sync, active-high); bus = gpio_apb_arb_if.slave (requesters + APB).
module gpio_apb_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic           pclk,
  input  logic           p_reset,
  gpio_apb_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              lock_q, lock_d;
  logic              owner_q, owner_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0] req;
  logic       accept;
  logic       locked_win;
  logic       winner;

  assign req = {bus.req1_req, bus.req0_req};

  // Acceptance is possible in every state except SETUP, which lets ACCESS
  // overlap the next grant and gives back-to-back transfers with no gap.
  always_comb begin
    accept     = (state_q != SETUP) && (req != 2'b00);
    // A held lock only wins while its owner is still requesting; otherwise
    // the lock is ignored this cycle and cleared by the acceptance below.
    locked_win = lock_q && req[owner_q];
    if (locked_win)         winner = owner_q;
    else if (req == 2'b11)  winner = ptr_q;
    else                    winner = req[1];
  end

  assign bus.req0_gnt = accept && !winner;
  assign bus.req1_gnt = accept &&  winner;

  // State register
  always_ff @(posedge pclk) begin
    if (p_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = accept ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / bookkeeping logic
  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    owner_d   = owner_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    // APB strobes are registered from the next state so they line up with it.
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
    // Completion uses the owner/direction of the transfer ending now; any
    // acceptance in this same ACCESS cycle only updates the _d copies.
    done0_d   = (state_q == ACCESS) && !owner_q;
    done1_d   = (state_q == ACCESS) &&  owner_q;
    if ((state_q == ACCESS) && !pwrite_q) begin
      if (owner_q) rdata1_d = bus.prdata;
      else         rdata0_d = bus.prdata;
    end
    if (accept) begin
      if (!locked_win) ptr_d = ~winner;
      lock_d   = winner ? bus.req1_lock  : bus.req0_lock;
      owner_d  = winner;
      pwrite_d = winner ? bus.req1_we    : bus.req0_we;
      paddr_d  = winner ? bus.req1_addr  : bus.req0_addr;
      pwdata_d = winner ? bus.req1_wdata : bus.req0_wdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      ptr_q     <= 1'b0;
      lock_q    <= 1'b0;
      owner_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.req0_done  = done0_q;
  assign bus.req1_done  = done1_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;

endmodule

// File: tb/tb_gpio_apb_arb.sv
// Purpose : scoreboard bench for gpio_apb_arb; directed scenarios followed by random traffic.
// Model   : a bus accepts in any cycle not directly after an acceptance; winner from lock/pointer rules.
// Monitor : pops expected transfers on APB setup/access and on done pulses.
module tb_gpio_apb_arb;

  logic pclk = 1'b0;
  logic p_reset = 1'b1;
  always #5 pclk = ~pclk;

  gpio_apb_arb_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  gpio_apb_arb #(.ADDR_W(6), .DATA_W(32)) dut (
    .pclk    (pclk),
    .p_reset (p_reset),
    .bus     (bus)
  );

  typedef struct {
    bit          req;
    bit          we;
    bit          lock;
    logic [5:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int          port;
    bit          we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          acc;
  } xfer_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  xfer_t       apb_q[$];
  xfer_t       done_q[$];
  logic [31:0] prd_hist [0:4095];
  logic [31:0] held [0:1];
  bit          have_setup = 0;
  xfer_t       cur;

  // reference-model state
  bit m_ptr = 0, m_lock = 0, m_owner = 0, m_prev = 0;
  bit m_g0 = 0, m_g1 = 0;

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic req_t mk(input bit r, input bit we, input logic [5:0] a,
                              input logic [31:0] d, input bit l);
    req_t q;
    q.req = r; q.we = we; q.addr = a; q.data = d; q.lock = l;
    return q;
  endfunction

  function automatic req_t rnd();
    req_t q;
    q.req  = ($urandom_range(0, 2) != 0);
    q.we   = ($urandom_range(0, 1) != 0);
    q.lock = ($urandom_range(0, 3) == 0);
    q.addr = 6'($urandom);
    q.data = $urandom;
    return q;
  endfunction

  // One clock cycle: apply inputs after the edge, then at the falling edge
  // compare grants with the model and record accepted transfers.
  task automatic drive(input bit rst, input req_t q0, input req_t q1, input logic [31:0] pd);
    bit [1:0] r;
    bit       can, lw, w;
    xfer_t    x;
    @(posedge pclk);
    #1;
    p_reset        = rst;
    bus.req0_req   = q0.req;  bus.req0_we   = q0.we;   bus.req0_addr = q0.addr;
    bus.req0_wdata = q0.data; bus.req0_lock = q0.lock;
    bus.req1_req   = q1.req;  bus.req1_we   = q1.we;   bus.req1_addr = q1.addr;
    bus.req1_wdata = q1.data; bus.req1_lock = q1.lock;
    bus.prdata     = pd;
    prd_hist[cyc % 4096] = pd;
    @(negedge pclk);
    r   = {q1.req, q0.req};
    can = !m_prev && (r != 2'b00);
    lw  = m_lock && r[m_owner];
    if (lw)               w = m_owner;
    else if (r == 2'b11)  w = m_ptr;
    else                  w = r[1];
    chk("gnt0", 32'(bus.req0_gnt), 32'(can && !w));
    chk("gnt1", 32'(bus.req1_gnt), 32'(can && w));
    m_g0 = can && !w;
    m_g1 = can && w;
    if (rst) begin
      m_ptr = 0; m_lock = 0; m_owner = 0; m_prev = 0;
    end else begin
      if (can) begin
        x.port  = w ? 1 : 0;
        x.we    = w ? q1.we   : q0.we;
        x.addr  = w ? q1.addr : q0.addr;
        x.wdata = w ? q1.data : q0.data;
        x.acc   = cyc;
        apb_q.push_back(x);
        done_q.push_back(x);
        if (!lw) m_ptr = !w;
        m_lock  = w ? q1.lock : q0.lock;
        m_owner = w;
      end
      m_prev = can;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 32'h0);
  endtask

  // Monitor: APB phases and done pulses against the expected-transfer queues.
  initial forever begin
    xfer_t       e;
    logic [31:0] exp;
    @(negedge pclk);
    if (bus.psel && !bus.penable) begin
      if (have_setup) flag("setup_twice");
      if (apb_q.size() == 0) flag("unexpected_setup");
      else begin
        cur = apb_q.pop_front();
        chk("setup_cycle", 32'(cyc), 32'(cur.acc + 1));
        chk("setup_pwrite", 32'(bus.pwrite), 32'(cur.we));
        chk("setup_paddr", 32'(bus.paddr), 32'(cur.addr));
        chk("setup_pwdata", bus.pwdata, cur.wdata);
        have_setup = 1;
      end
    end else if (bus.psel && bus.penable) begin
      if (!have_setup) flag("access_without_setup");
      else begin
        chk("access_cycle", 32'(cyc), 32'(cur.acc + 2));
        chk("access_pwrite", 32'(bus.pwrite), 32'(cur.we));
        chk("access_paddr", 32'(bus.paddr), 32'(cur.addr));
        chk("access_pwdata", bus.pwdata, cur.wdata);
      end
      have_setup = 0;
    end else begin
      if (bus.penable) flag("penable_without_psel");
      if (have_setup) flag("setup_without_access");
      have_setup = 0;
    end
    if (bus.req0_done && bus.req1_done) flag("double_done");
    else if (bus.req0_done || bus.req1_done) begin
      if (done_q.size() == 0) flag("unexpected_done");
      else begin
        e = done_q.pop_front();
        chk("done_port", 32'(bus.req1_done ? 1 : 0), 32'(e.port));
        chk("done_cycle", 32'(cyc), 32'(e.acc + 3));
        exp = e.we ? held[e.port] : prd_hist[(e.acc + 2) % 4096];
        held[e.port] = exp;
        chk("done_rdata", e.port == 1 ? bus.req1_rdata : bus.req0_rdata, exp);
      end
    end
    if (p_reset) begin
      apb_q.delete();
      done_q.delete();
      have_setup = 0;
      held[0] = '0;
      held[1] = '0;
    end
  end

  initial begin
    req_t no, a, b, c0, c1;
    no = mk(0, 0, 0, 0, 0);
    held[0] = '0;
    held[1] = '0;
    bus.req0_req = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_lock = 0;
    bus.req1_req = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_lock = 0;
    bus.prdata = '0;
    repeat (2) @(negedge pclk);

    // reset state
    chk("rst_psel", 32'(bus.psel), 0);
    chk("rst_penable", 32'(bus.penable), 0);
    chk("rst_pwrite", 32'(bus.pwrite), 0);
    chk("rst_paddr", 32'(bus.paddr), 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_done", 32'({bus.req1_done, bus.req0_done}), 0);
    chk("rst_rdata0", bus.req0_rdata, 0);
    chk("rst_rdata1", bus.req1_rdata, 0);

    // single read
    drive(0, mk(1, 0, 6'h04, 32'h0, 0), no, 32'h0);
    chk("rd_gnt0", 32'(bus.req0_gnt), 1);
    drive(0, no, no, 32'h0);
    chk("rd_setup", 32'({bus.psel, bus.penable}), 32'b10);
    drive(0, no, no, 32'h0000_A5A5);
    chk("rd_access", 32'({bus.psel, bus.penable}), 32'b11);
    drive(0, no, no, 32'h0);
    chk("rd_done0", 32'(bus.req0_done), 1);
    chk("rd_rdata0", bus.req0_rdata, 32'h0000_A5A5);
    drive(0, mk(1, 1, 6'h01, 32'h1, 0), mk(1, 1, 6'h02, 32'h2, 0), 32'h0);
    chk("rd_ptr_is_1", 32'(bus.req1_gnt), 1);
    idle(4);

    // simultaneous writes after reset
    drive(1, no, no, 32'h0);
    a = mk(1, 1, 6'h00, 32'h11, 0);
    b = mk(1, 1, 6'h08, 32'h22, 0);
    drive(0, a, b, 32'h0);
    chk("sim_gnt0", 32'(bus.req0_gnt), 1);
    drive(0, no, b, 32'h0);
    chk("sim_pwdata_a1", bus.pwdata, 32'h11);
    drive(0, no, b, 32'h0);
    chk("sim_gnt1", 32'(bus.req1_gnt), 1);
    chk("sim_pwdata_a2", bus.pwdata, 32'h11);
    drive(0, no, no, 32'h0);
    chk("sim_done0", 32'(bus.req0_done), 1);
    chk("sim_pwdata_a3", bus.pwdata, 32'h22);
    drive(0, no, no, 32'h0);
    drive(0, no, no, 32'h0);
    chk("sim_done1", 32'(bus.req1_done), 1);
    idle(2);

    // locked read-modify-write by requester 1
    drive(1, no, no, 32'h0);
    a = mk(1, 1, 6'h10, 32'h55, 0);
    drive(0, no, mk(1, 0, 6'h0C, 32'h0, 1), 32'h0);
    chk("rmw_rd_gnt1", 32'(bus.req1_gnt), 1);
    drive(0, a, mk(1, 1, 6'h0C, 32'hABCD, 0), 32'h0);
    drive(0, a, mk(1, 1, 6'h0C, 32'hABCD, 0), 32'h1234);
    chk("rmw_wr_gnt1", 32'({bus.req1_gnt, bus.req0_gnt}), 32'b10);
    drive(0, a, no, 32'h0);
    drive(0, a, no, 32'h0);
    chk("rmw_then_gnt0", 32'(bus.req0_gnt), 1);
    idle(4);

    // lock released when owner drops its request
    a = mk(1, 0, 6'h04, 32'h0, 0);
    drive(0, no, mk(1, 0, 6'h0C, 32'h0, 1), 32'h0);
    drive(0, a, no, 32'h0);
    drive(0, a, no, 32'h77);
    chk("release_gnt0", 32'(bus.req0_gnt), 1);
    a = mk(1, 1, 6'h05, 32'h5, 0);
    b = mk(1, 1, 6'h06, 32'h6, 0);
    drive(0, a, b, 32'h0);
    drive(0, a, b, 32'h0);
    chk("release_lock_cleared", 32'({bus.req1_gnt, bus.req0_gnt}), 32'b10);
    idle(4);

    // reset during SETUP of a req0 read
    drive(1, no, no, 32'h0);
    drive(0, mk(1, 0, 6'h04, 32'h0, 0), no, 32'h0);
    drive(1, no, no, 32'h0);
    drive(0, no, no, 32'hDEAD_BEEF);
    chk("midrst_psel", 32'(bus.psel), 0);
    chk("midrst_penable", 32'(bus.penable), 0);
    drive(0, mk(1, 1, 6'h01, 32'h9, 0), mk(1, 1, 6'h02, 32'hA, 0), 32'h0);
    chk("midrst_no_done", 32'(bus.req0_done), 0);
    chk("midrst_rdata0", bus.req0_rdata, 0);
    chk("midrst_prio0", 32'(bus.req0_gnt), 1);
    idle(5);

    // random traffic
    c0 = no;
    c1 = no;
    for (int i = 0; i < 1000; i++) begin
      if (m_g0 || $urandom_range(0, 3) == 0) c0 = rnd();
      if (m_g1 || $urandom_range(0, 3) == 0) c1 = rnd();
      drive(0, c0, c1, $urandom);
    end
    idle(6);
    chk("drain_apb", 32'(apb_q.size()), 0);
    chk("drain_done", 32'(done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_apb_arb.md
# gpio_apb_arb

Two-requester APB bus arbiter and transfer sequencer that shares one gpio_lite register port between a CPU-side request interface (port 0) and a power/test sequencer (port 1). It accepts simple level-request transfers and serialises them as APB setup/access phase pairs. Requesters are granted round-robin, with an optional lock for read-modify-write sequences. It sits directly in front of the gpio_lite psel/penable/pwrite/paddr/pwdata/prdata pins.

## Interface
- ADDR_W, 6: APB address width (matches gpio_lite paddr).
- DATA_W, 32: APB data width.
- pclk  in  1  APB clock; all logic on rising edge.
- p_reset  in  1  reset; one clock; reset is synchronous and active-high.
- reqN_req  in  1  (N=0,1) transfer request, level.
- reqN_we  in  1  1 = write, 0 = read; sampled at acceptance.
- reqN_addr  in  ADDR_W  register address; sampled at acceptance.
- reqN_wdata  in  DATA_W  write data; sampled at acceptance.
- reqN_lock  in  1  keep ownership for next transfer; sampled at acceptance.
- reqN_gnt  out  1  combinational; high in the acceptance cycle.
- reqN_done  out  1  registered one-cycle completion pulse.
- reqN_rdata  out  DATA_W  last read data for this requester, held.
- psel  out  1  APB select, registered.
- penable  out  1  APB enable, registered.
- pwrite  out  1  APB direction, registered.
- paddr  out  ADDR_W  APB address, registered.
- pwdata  out  DATA_W  APB write data, registered.
- prdata  in  DATA_W  APB read data from gpio_lite.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Acceptance cycle: the FSM is in IDLE or ACCESS and at least one reqN_req is high.
- At acceptance:
  - The winner's we/addr/wdata/lock are latched.
  - reqN_gnt = 1 for the winner only.
  - Next state is SETUP.
- ACCESS with no request goes to IDLE.
- SETUP: psel=1, penable=0, pwrite/paddr/pwdata = latched values. Next state is always ACCESS.
- ACCESS: psel=1, penable=1, same pwrite/paddr/pwdata.
- Read completion: prdata is captured into the owner's reqN_rdata at the end of ACCESS. Writes leave reqN_rdata unchanged.
- reqN_done pulses in the cycle after ACCESS, for every transfer.
- Arbitration:
  - A 1-bit priority pointer favours one requester when both request. It resets to 0.
  - After each non-locked acceptance, the pointer points to the other requester.
  - Lock: if the last accepted transfer had lock=1, the next acceptance considers only that owner, provided its req is high.
  - If the locked owner's req is low at an acceptance opportunity, the lock is released and normal round-robin applies in that same cycle.
  - A locked acceptance does not move the pointer. Lock has no timeout.
- A requester keeps req high to issue further transfers. It must present the next transfer's fields, or drop req, in the cycle after gnt.
- Reset:
  - State goes to IDLE; pointer, lock flag, and psel/penable/pwrite/paddr/pwdata/reqN_done/reqN_rdata all go to 0.
  - A transfer in flight is abandoned: no done pulse, and rdata is not updated.

## Timing
- Acceptance in cycle A gives SETUP at A+1, ACCESS at A+2, and done (with rdata valid) at A+3.
- Back-to-back: acceptance in ACCESS cycle A+2 gives the next SETUP at A+3, with no IDLE gap. Peak throughput is one transfer per 2 cycles.
- A single isolated transfer occupies the bus for 2 cycles. psel is never high for more than 2 consecutive cycles on one transfer.
- penable never rises without psel having been high, with penable low, in the prior cycle.
- reqN_gnt is combinational from state, req, pointer and lock. All other outputs are registered.
- Reset asserted on any edge takes effect on that edge; outputs are 0 in the following cycle.

## Test plan
- Single read: req0, we=0, addr=0x04 in IDLE; prdata=0x0000_A5A5 during ACCESS.
  - Required: gnt0 in cycle A; psel=1/penable=0 at A+1; psel=1/penable=1 at A+2; done0 at A+3; rdata0=0x0000_A5A5; pointer=1.
- Simultaneous requests after reset: req0 writes 0x11 to 0x00 and req1 writes 0x22 to 0x08, both from cycle A.
  - Required: req0 served first (pwdata=0x11 at A+1/A+2); req1 accepted at A+2, pwdata=0x22 at A+3/A+4; done0 at A+3, done1 at A+5.
- Lock RMW: req1 reads 0x0C with lock=1, then writes 0x0C with lock=0, while req0 requests continuously.
  - Required: req1's write is accepted back-to-back before any req0 grant; req0 is granted at the next opportunity after that.
- Lock release: req1 locks, then drops req while req0 requests.
  - Required: req0 is granted at the next acceptance opportunity; the lock flag is cleared.
- Reset mid-transfer: assert p_reset in the SETUP cycle of a req0 read.
  - Required: next cycle psel=penable=0, no done0 ever for that transfer, rdata0=0; a new req1 request is then served with pointer=0 behaviour (req0 priority if both request).
- Protocol check over 1000 random req/we/lock cycles: no SETUP without a following ACCESS, no overlapping grants, and every gnt matched by exactly one done.
